// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// i2c_pkg : FSM state encoding, register pointers and reset values shared by
//           the I2C ADC responder and its bus synchronizer.
// Revision: 1.0
// ============================================================================
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR_BYTE   = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD_BYTE   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  localparam logic [1:0] PTR_CONV = 2'd0;
  localparam logic [1:0] PTR_CFG  = 2'd1;
  localparam logic [1:0] PTR_LO   = 2'd2;
  localparam logic [1:0] PTR_HI   = 2'd3;

  localparam logic [15:0] RST_CONV = 16'h0000;
  localparam logic [15:0] RST_CFG  = 16'h8583;
  localparam logic [15:0] RST_LO   = 16'h8000;
  localparam logic [15:0] RST_HI   = 16'h7FFF;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// i2c_bus_sync : SCL/SDA synchronizers with SCL edge and START/STOP detection.
// Revision: 1.0
// ============================================================================
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl;

  // Idle bus is high, so reset to 1 to avoid a spurious edge out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl      = scl_sync[SYNC_STAGES-1];
  assign sda      = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_prev;
  assign scl_fall = ~scl & scl_prev;
  assign start    = scl & scl_prev & sda_prev & ~sda;
  assign stop     = scl & scl_prev & ~sda_prev & sda;

endmodule
`default_nettype wire

// File: rtl/i2c_adc_responder.sv
`default_nettype none
// ============================================================================
// i2c_adc_responder : I2C target emulating a four-register ADC at SLAVE_ADDR.
//                     Define I2C_ADC_RESPONDER_ALERT_EN to add the alert_n output.
// Revision: 1.0
// ============================================================================
module i2c_adc_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h48,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire         scl_pin,
  inout  wire         sda_pin,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  output logic [15:0] config_reg,
  output logic        config_wr,
  output logic        busy
`ifdef I2C_ADC_RESPONDER_ALERT_EN
  ,
  output logic        alert_n
`endif
);

  logic        sda, scl_rise, scl_fall, start, stop;
  state_t      state;
  logic [3:0]  bit_cnt;
  logic [7:0]  rx_byte;
  logic [6:0]  tx_rest;
  logic [7:0]  data_hi;
  logic [15:0] snap;
  logic [1:0]  ptr;
  logic [1:0]  byte_idx;
  logic        rw, rd_half, master_ack, sda_oe;
  logic [15:0] conv_reg, lo_reg, hi_reg;
  logic [15:0] rd_val;
  logic [7:0]  next_byte;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_pin),
    .sda_in   (sda_pin),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign sda_pin = sda_oe ? 1'b0 : 1'bz;

  always_comb begin
    rd_val = conv_reg;
    case (ptr)
      PTR_CFG: rd_val = config_reg;
      PTR_LO:  rd_val = lo_reg;
      PTR_HI:  rd_val = hi_reg;
      default: rd_val = conv_reg;
    endcase
  end

  assign next_byte = rd_half ? snap[7:0] : snap[15:8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conv_reg <= RST_CONV;
    end else if (sample_valid) begin
      conv_reg <= sample_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= 4'd0;
      rx_byte    <= 8'h00;
      tx_rest    <= 7'h00;
      data_hi    <= 8'h00;
      snap       <= 16'h0000;
      ptr        <= PTR_CONV;
      byte_idx   <= 2'd0;
      rw         <= 1'b0;
      rd_half    <= 1'b0;
      master_ack <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      config_reg <= RST_CFG;
      lo_reg     <= RST_LO;
      hi_reg     <= RST_HI;
      config_wr  <= 1'b0;
    end else begin
      config_wr <= 1'b0;
      if (start) begin
        state   <= ST_ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_WR_BYTE: begin
            if (scl_rise) begin
              rx_byte <= {rx_byte[6:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (state == ST_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  rw       <= rx_byte[0];
                  snap     <= rd_val;
                  rd_half  <= 1'b0;
                  byte_idx <= 2'd0;
                  sda_oe   <= 1'b1;
                  state    <= ST_ADDR_ACK;
                end else begin
                  state <= ST_WAIT_STOP;
                end
              end else if (byte_idx == 2'd3) begin
                state <= ST_WAIT_STOP;
              end else begin
                sda_oe <= 1'b1;
                state  <= ST_WR_ACK;
                case (byte_idx)
                  2'd0:    ptr     <= rx_byte[1:0];
                  2'd1:    data_hi <= rx_byte;
                  default: begin
                    // Conversion register is read-only: pointer 0 writes are dropped
                    case (ptr)
                      PTR_CFG: begin
                        config_reg <= {data_hi, rx_byte};
                        config_wr  <= 1'b1;
                      end
                      PTR_LO:  lo_reg <= {data_hi, rx_byte};
                      PTR_HI:  hi_reg <= {data_hi, rx_byte};
                      default: ;
                    endcase
                  end
                endcase
              end
            end
          end
          ST_ADDR_ACK, ST_WR_ACK: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd1) begin
              bit_cnt <= 4'd0;
              if (state == ST_ADDR_ACK && rw) begin
                tx_rest <= next_byte[6:0];
                sda_oe  <= ~next_byte[7];
                rd_half <= ~rd_half;
                state   <= ST_RD_BYTE;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_WR_BYTE;
                if (state == ST_WR_ACK) begin
                  byte_idx <= byte_idx + 2'd1;
                end
              end
            end
          end
          ST_RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                state   <= ST_RD_ACK;
              end else if (bit_cnt != 4'd0) begin
                sda_oe  <= ~tx_rest[6];
                tx_rest <= {tx_rest[5:0], 1'b0};
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              master_ack <= ~sda;
              bit_cnt    <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd1) begin
              bit_cnt <= 4'd0;
              if (master_ack) begin
                tx_rest <= next_byte[6:0];
                sda_oe  <= ~next_byte[7];
                rd_half <= ~rd_half;
                state   <= ST_RD_BYTE;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef I2C_ADC_RESPONDER_ALERT_EN
  logic conv_rd_done;
  assign conv_rd_done = !start && !stop && (state == ST_ADDR_ACK) && rw &&
                        scl_fall && (bit_cnt == 4'd1) && (ptr == PTR_CONV);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alert_n <= 1'b1;
    end else if (sample_valid && (($signed(sample_data) > $signed(hi_reg)) ||
                                  ($signed(sample_data) < $signed(lo_reg)))) begin
      alert_n <= 1'b0;
    end else if (conv_rd_done) begin
      alert_n <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_adc_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_i2c_adc_responder : bit-banged I2C master with scoreboard and vector table.
// Revision: 1.0
// ============================================================================
module tb_i2c_adc_responder;

  localparam int Q = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [15:0] sample_data = 16'h0000;
  logic        sample_valid = 1'b0;
  logic [15:0] config_reg;
  logic        config_wr;
  logic        busy;
`ifdef I2C_ADC_RESPONDER_ALERT_EN
  logic        alert_n;
`endif
  wire         scl_pin;
  wire         sda_pin;

  assign scl_pin = m_scl ? 1'bz : 1'b0;
  assign sda_pin = m_sda ? 1'bz : 1'b0;
  pullup (scl_pin);
  pullup (sda_pin);

  always #4 clk = ~clk;

  i2c_adc_responder #(.SLAVE_ADDR(7'h48), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .scl_pin      (scl_pin),
    .sda_pin      (sda_pin),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .config_reg   (config_reg),
    .config_wr    (config_wr),
    .busy         (busy)
`ifdef I2C_ADC_RESPONDER_ALERT_EN
    ,
    .alert_n      (alert_n)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cfg_wr_cnt = 0;
  int sda_low_cnt = 0;

  always @(negedge clk) begin
    if (config_wr === 1'b1) cfg_wr_cnt++;
    if (m_sda && sda_pin === 1'b0) sda_low_cnt++;
  end

  string       sb_name[$];
  logic [15:0] sb_exp[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input string name, input logic [15:0] exp);
    sb_name.push_back(name);
    sb_exp.push_back(exp);
  endtask

  task automatic sb_pop(input logic [15:0] act);
    string       nm;
    logic [15:0] ex;
    if (sb_exp.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_empty: got %h expected nothing", act);
    end else begin
      nm = sb_name.pop_front();
      ex = sb_exp.pop_front();
      check(nm, act, ex);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_out(input logic b);
    m_sda = b;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic bit_in(output logic b);
    m_sda = 1'b1;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    b = sda_pin;
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    m_sda = 1'b0;
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    m_sda = 1'b1;
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic a;
    sb_push(name, {15'd0, exp_ack});
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    bit_in(a);
    sb_pop({15'd0, a});
  endtask

  task automatic recv_byte(input logic [7:0] exp, input logic nack, input string name);
    logic [7:0] d;
    logic       b;
    sb_push(name, {8'd0, exp});
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
    bit_out(nack);
    sb_pop({8'd0, d});
  endtask

  task automatic pulse_sample(input logic [15:0] v);
    @(negedge clk);
    sample_data  = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic write_reg(input logic [7:0] pb, input logic [15:0] v, input string name);
    i2c_start();
    send_byte(8'h90, 1'b0, {name, "_wa"});
    send_byte(pb, 1'b0, {name, "_wp"});
    send_byte(v[15:8], 1'b0, {name, "_wm"});
    send_byte(v[7:0], 1'b0, {name, "_wl"});
    i2c_stop();
  endtask

  task automatic read_reg(input logic [7:0] pb, input logic [15:0] exp, input string name);
    i2c_start();
    send_byte(8'h90, 1'b0, {name, "_ra"});
    send_byte(pb, 1'b0, {name, "_rp"});
    i2c_start();
    send_byte(8'h91, 1'b0, {name, "_rr"});
    recv_byte(exp[15:8], 1'b0, {name, "_msb"});
    recv_byte(exp[7:0], 1'b1, {name, "_lsb"});
    i2c_stop();
  endtask

  typedef struct packed {
    logic        do_wr;
    logic [7:0]  ptr_byte;
    logic [15:0] wdata;
    logic [15:0] exp;
    logic        exp_wr;
  } vec_t;

  vec_t vecs [10];

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_wr;
    int base_low;

    vecs[0] = '{1'b0, 8'h01, 16'h0000, 16'h4243, 1'b0};
    vecs[1] = '{1'b0, 8'h02, 16'h0000, 16'h8000, 1'b0};
    vecs[2] = '{1'b0, 8'h03, 16'h0000, 16'h7FFF, 1'b0};
    vecs[3] = '{1'b1, 8'h02, 16'h1111, 16'h1111, 1'b0};
    vecs[4] = '{1'b1, 8'h03, 16'h2222, 16'h2222, 1'b0};
    vecs[5] = '{1'b1, 8'hFD, 16'hBEEF, 16'hBEEF, 1'b1};
    vecs[6] = '{1'b1, 8'h00, 16'h5555, 16'hABCD, 1'b0};
    vecs[7] = '{1'b1, 8'h01, 16'h8583, 16'h8583, 1'b1};
    vecs[8] = '{1'b1, 8'h02, 16'h8000, 16'h8000, 1'b0};
    vecs[9] = '{1'b1, 8'h03, 16'h7FFF, 16'h7FFF, 1'b0};

    #2 reset = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_sda", 16'(sda_pin), 16'd1);
    check("rst_config_reg", config_reg, 16'h8583);
    check("rst_config_wr", 16'(config_wr), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
`ifdef I2C_ADC_RESPONDER_ALERT_EN
    check("rst_alert_n", 16'(alert_n), 16'd1);
`endif
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Config write
    base_wr = cfg_wr_cnt;
    i2c_start();
    check("busy_after_start", 16'(busy), 16'd1);
    send_byte(8'h90, 1'b0, "w1_addr_ack");
    send_byte(8'h01, 1'b0, "w1_ptr_ack");
    send_byte(8'h42, 1'b0, "w1_msb_ack");
    send_byte(8'h43, 1'b0, "w1_lsb_ack");
    i2c_stop();
    repeat (4) @(negedge clk);
    check("w1_busy_after_stop", 16'(busy), 16'd0);
    check("w1_config_reg", config_reg, 16'h4243);
    check("w1_config_wr_pulses", 16'(cfg_wr_cnt - base_wr), 16'd1);

    // Conversion read through repeated START
    pulse_sample(16'h1234);
    i2c_start();
    send_byte(8'h90, 1'b0, "r1_addr_ack");
    send_byte(8'h00, 1'b0, "r1_ptr_ack");
    i2c_start();
    send_byte(8'h91, 1'b0, "r1_raddr_ack");
    recv_byte(8'h12, 1'b0, "r1_msb");
    recv_byte(8'h34, 1'b1, "r1_lsb");
    i2c_stop();
    repeat (4) @(negedge clk);
    check("r1_busy_after_stop", 16'(busy), 16'd0);

    // Foreign address: never ACKed, no effect
    base_wr  = cfg_wr_cnt;
    base_low = sda_low_cnt;
    i2c_start();
    send_byte(8'h92, 1'b1, "na_addr_nack");
    send_byte(8'h01, 1'b1, "na_b1_nack");
    send_byte(8'h55, 1'b1, "na_b2_nack");
    i2c_stop();
    repeat (4) @(negedge clk);
    check("na_sda_never_driven", 16'(sda_low_cnt - base_low), 16'd0);
    check("na_config_reg", config_reg, 16'h4243);
    check("na_config_wr_pulses", 16'(cfg_wr_cnt - base_wr), 16'd0);
    i2c_start();
    send_byte(8'h91, 1'b0, "na_ptr_kept_ack");
    recv_byte(8'h12, 1'b0, "na_ptr_kept_msb");
    recv_byte(8'h34, 1'b1, "na_ptr_kept_lsb");
    i2c_stop();

    // New sample mid-read must not disturb the snapshot
    i2c_start();
    send_byte(8'h91, 1'b0, "sn_addr_ack");
    recv_byte(8'h12, 1'b0, "sn_msb_old");
    pulse_sample(16'hABCD);
    recv_byte(8'h34, 1'b1, "sn_lsb_old");
    i2c_stop();
    i2c_start();
    send_byte(8'h91, 1'b0, "sn2_addr_ack");
    recv_byte(8'hAB, 1'b0, "sn2_msb");
    recv_byte(8'hCD, 1'b0, "sn2_lsb");
    recv_byte(8'hAB, 1'b0, "sn2_msb_rep");
    recv_byte(8'hCD, 1'b1, "sn2_lsb_rep");
    i2c_stop();

    // Register table
    for (int i = 0; i < 10; i++) begin
      base_wr = cfg_wr_cnt;
      if (vecs[i].do_wr) write_reg(vecs[i].ptr_byte, vecs[i].wdata, $sformatf("v%0d", i));
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_config_wr", i), 16'(cfg_wr_cnt - base_wr), 16'(vecs[i].exp_wr));
      read_reg(vecs[i].ptr_byte, vecs[i].exp, $sformatf("v%0d", i));
    end

    // Five-byte write: the fourth data byte is refused
    base_wr = cfg_wr_cnt;
    i2c_start();
    send_byte(8'h90, 1'b0, "w5_addr_ack");
    send_byte(8'h01, 1'b0, "w5_ptr_ack");
    send_byte(8'h11, 1'b0, "w5_msb_ack");
    send_byte(8'h22, 1'b0, "w5_lsb_ack");
    send_byte(8'h33, 1'b1, "w5_extra_nack");
    i2c_stop();
    repeat (4) @(negedge clk);
    check("w5_config_reg", config_reg, 16'h1122);
    check("w5_config_wr_pulses", 16'(cfg_wr_cnt - base_wr), 16'd1);

    // Reset while the responder is driving a read bit low
    i2c_start();
    send_byte(8'h91, 1'b0, "rm_addr_ack");
    m_sda = 1'b1;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    check("rm_sda_driven_before", 16'(sda_pin), 16'd0);
    reset = 1'b1;
    #1;
    check("rm_sda_released", 16'(sda_pin), 16'd1);
    check("rm_config_reg", config_reg, 16'h8583);
    check("rm_busy", 16'(busy), 16'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    i2c_start();
    send_byte(8'h91, 1'b0, "rm_conv_ack");
    recv_byte(8'h00, 1'b0, "rm_conv_msb");
    recv_byte(8'h00, 1'b1, "rm_conv_lsb");
    i2c_stop();

`ifdef I2C_ADC_RESPONDER_ALERT_EN
    write_reg(8'h03, 16'h0100, "al_hi");
    repeat (2) @(negedge clk);
    check("al_idle_high", 16'(alert_n), 16'd1);
    pulse_sample(16'h0200);
    @(negedge clk);
    check("al_asserted", 16'(alert_n), 16'd0);
    read_reg(8'h00, 16'h0200, "al_conv");
    check("al_cleared", 16'(alert_n), 16'd1);
`endif

    repeat (4) @(negedge clk);
    if (sb_exp.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
